// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider.
// Holds the operand width, result width, div_op bit positions and the FSM
// state encoding used by the divider and its handshake interface.
package iter_divider_pkg;

    localparam int DIV_DW        = 32;
    localparam int DIV_RESULT_WD = 2 * DIV_DW;

    // Bit positions within div_op. When both bits are set, the op is
    // treated as signed.
    localparam int DIV_OP_SIGNED   = 0;
    localparam int DIV_OP_UNSIGNED = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// EXE-stage divide handshake.
//   master (EXE)    : drives div_op, dividend, divisor, div_in_valid, div_out_ready
//   slave  (divider): drives div_in_ready, div_result, div_out_valid
// div_result = {remainder, quotient}. The upper half goes to HI and the
// lower half goes to LO.
interface iter_divider_if
    import iter_divider_pkg::*;
    #(parameter int DW = DIV_DW) ();

    logic [1:0]      div_op;
    logic [DW-1:0]   dividend;
    logic [DW-1:0]   divisor;
    logic            div_in_valid;
    logic            div_in_ready;
    logic [2*DW-1:0] div_result;
    logic            div_out_valid;
    logic            div_out_ready;

    modport master (
        output div_op, dividend, divisor, div_in_valid, div_out_ready,
        input  div_in_ready, div_result, div_out_valid
    );

    modport slave (
        input  div_op, dividend, divisor, div_in_valid, div_out_ready,
        output div_in_ready, div_result, div_out_valid
    );

endinterface

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division step.
//   rem_i     : partial remainder (always less than the divisor)
//   bit_i     : next dividend bit, shifted into the bottom of the remainder
//   divisor_i : divisor magnitude, DW+1 bits
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW:0]   divisor_i,
    output logic [DW-1:0] rem_o,
    output logic          q_o
);

    logic [DW:0] shifted;
    logic [DW:0] diff;

    // rem_i < divisor_i <= 2^DW, so the shifted value fits in DW+1 bits.
    // After either the subtract or the restore, the result is again below
    // the divisor and fits in DW bits.
    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= divisor_i);
    assign diff    = shifted - divisor_i;
    assign rem_o   = q_o ? diff[DW-1:0] : shifted[DW-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider. It is the responder on the EXE
// divide handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of iter_divider_if (request in, {rem, quot} out)
// The divider accepts a request in IDLE, runs DW steps in BUSY, and then
// holds the sign-corrected result in DONE until div_out_ready is seen.
module iter_divider
    import iter_divider_pkg::*;
    #(parameter int DW = DIV_DW) (
    input  logic         clk,
    input  logic         reset,
    iter_divider_if.slave bus
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   rem_q, rem_d;       // partial remainder
    logic [DW-1:0]   dvd_q, dvd_d;       // dividend bits out, quotient bits in
    logic [DW:0]     dsr_q, dsr_d;       // divisor magnitude
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [2*DW-1:0] result_q, result_d;

    logic            is_signed, op_valid, a_neg, b_neg;
    logic [DW-1:0]   step_rem, q_raw;
    logic            step_q;

    div_step #(.DW(DW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so
        // paths that do not assign it cannot infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        is_signed = bus.div_op[DIV_OP_SIGNED];
        op_valid  = bus.div_op[DIV_OP_SIGNED] | bus.div_op[DIV_OP_UNSIGNED];
        a_neg     = is_signed & bus.dividend[DW-1];
        b_neg     = is_signed & bus.divisor[DW-1];
        q_raw     = {dvd_q[DW-2:0], step_q};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.div_in_valid && op_valid) begin
                    state_d = ST_BUSY;
                    count_d = '0;
                    rem_d   = '0;
                    dvd_d   = a_neg ? -bus.dividend : bus.dividend;
                    dsr_d   = {1'b0, (b_neg ? -bus.divisor : bus.divisor)};
                    // Divide by zero gives an all-ones quotient regardless of
                    // sign. The remainder magnitude negates back to the raw
                    // dividend.
                    q_neg_d = (a_neg ^ b_neg) & (bus.divisor != '0);
                    r_neg_d = a_neg;
                end
            end
            ST_BUSY: begin
                rem_d   = step_rem;
                dvd_d   = q_raw;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d  = ST_DONE;
                    result_d = {(r_neg_q ? -step_rem : step_rem),
                                (q_neg_q ? -q_raw    : q_raw)};
                end
            end
            ST_DONE: begin
                if (bus.div_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples its pre-edge value.
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign bus.div_in_ready  = (state_q == ST_IDLE);
    assign bus.div_out_valid = (state_q == ST_DONE);
    assign bus.div_result    = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed and light random checks of iter_divider.
module tb_iter_divider;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    iter_divider_if #(.DW(32)) bus ();

    iter_divider #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncate-toward-zero division done in 64 bits, so the
    // signed overflow case does not trap. x/0 returns {x, all ones}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Issues one op. Checks the latency and the result, holds
    // div_out_ready low for 'stall' cycles in DONE, and then releases the
    // result.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input logic [63:0] exp);
        int cyc;
        bus.div_out_ready = (stall == 0);
        check({tag, "/in_ready"}, 64'(bus.div_in_ready), 64'd1);
        bus.div_op       = op;
        bus.dividend     = a;
        bus.divisor      = b;
        bus.div_in_valid = 1'b1;
        tick();
        bus.div_in_valid = 1'b0;
        bus.dividend     = $urandom;
        bus.divisor      = $urandom;
        bus.div_op       = 2'($urandom_range(0, 3));
        cyc = 0;
        while (!bus.div_out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "/latency"}, 64'(cyc), 64'd32);
        check({tag, "/result"}, bus.div_result, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "/hold_valid"}, 64'(bus.div_out_valid), 64'd1);
            check({tag, "/hold_ready"}, 64'(bus.div_in_ready), 64'd0);
            check({tag, "/hold_result"}, bus.div_result, exp);
        end
        bus.div_out_ready = 1'b1;
        tick();
        check({tag, "/back_idle"}, {62'd0, bus.div_in_ready, bus.div_out_valid}, 64'd2);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.div_op        = 2'b00;
        bus.dividend      = '0;
        bus.divisor       = '0;
        bus.div_in_valid  = 1'b0;
        bus.div_out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset/in_ready", 64'(bus.div_in_ready), 64'd1);
        check("reset/out_valid", 64'(bus.div_out_valid), 64'd0);
        check("reset/result", bus.div_result, 64'd0);

        // An op of 2'b00 must not be accepted.
        bus.div_op       = 2'b00;
        bus.dividend     = 32'd5;
        bus.divisor      = 32'd1;
        bus.div_in_valid = 1'b1;
        repeat (3) tick();
        bus.div_in_valid = 1'b0;
        check("op00/in_ready", 64'(bus.div_in_ready), 64'd1);
        check("op00/out_valid", 64'(bus.div_out_valid), 64'd0);

        do_op("divu_7_2",     2'b10, 32'd7,          32'd2,          0, {32'd1,          32'd3});
        do_op("div_m7_2",     2'b01, 32'hFFFF_FFF9,  32'd2,          0, {32'hFFFF_FFFF,  32'hFFFF_FFFD});
        do_op("div_7_m2",     2'b01, 32'd7,          32'hFFFF_FFFE,  0, {32'd1,          32'hFFFF_FFFD});
        do_op("op11_m7_2",    2'b11, 32'hFFFF_FFF9,  32'd2,          0, {32'hFFFF_FFFF,  32'hFFFF_FFFD});
        do_op("divu_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          0, {32'd1,          32'h7FFF_FFFC});
        do_op("div_ovf",      2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  0, {32'd0,          32'h8000_0000});
        do_op("divu_x_0",     2'b10, 32'h0000_1234,  32'd0,          0, {32'h0000_1234,  32'hFFFF_FFFF});
        do_op("div_x_0",      2'b01, 32'h0000_1234,  32'd0,          0, {32'h0000_1234,  32'hFFFF_FFFF});
        do_op("div_neg_0",    2'b01, 32'hFFFF_FFF9,  32'd0,          0, {32'hFFFF_FFF9,  32'hFFFF_FFFF});
        do_op("divu_max_1",   2'b10, 32'hFFFF_FFFF,  32'd1,          0, {32'd0,          32'hFFFF_FFFF});
        do_op("divu_1_max",   2'b10, 32'd1,          32'hFFFF_FFFF,  0, {32'd1,          32'd0});

        // Backpressure, then a request accepted right after the return to IDLE.
        do_op("bp_20_6",      2'b10, 32'd20,         32'd6,          5, {32'd2,          32'd3});
        do_op("after_bp",     2'b10, 32'd100,        32'd7,          0, {32'd2,          32'd14});

        // Reset while BUSY at count==10.
        bus.div_op       = 2'b10;
        bus.dividend     = 32'd50;
        bus.divisor      = 32'd5;
        bus.div_in_valid = 1'b1;
        tick();
        bus.div_in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst/out_valid", 64'(bus.div_out_valid), 64'd0);
        check("midrst/in_ready", 64'(bus.div_in_ready), 64'd1);
        check("midrst/result", bus.div_result, 64'd0);
        do_op("post_rst_9_3", 2'b10, 32'd9, 32'd3, 0, {32'd0, 32'd3});

        // Random pairs with occasional stalls; every tenth op divides by zero.
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(1, 3));
            a  = $urandom;
            b  = (n % 10 == 9) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (n % 7 == 0) a = a >> $urandom_range(0, 31);
            do_op("random", op, a, b, $urandom_range(0, 3), model(op, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
